// File: rtl/output_limit_ctrl_pkg.sv
// Shared state encoding and default word-count width for the output-limit path.
// The vendor-command block sizes its limit registers from OLC_WORD_CNT_W too.
package output_limit_ctrl_pkg;

    localparam int OLC_WORD_CNT_W = 16;

    typedef enum logic [1:0] {
        OLC_IDLE   = 2'd0,
        OLC_ACTIVE = 2'd1,
        OLC_DONE   = 2'd2
    } olc_state_e;

endpackage

// File: rtl/output_limit_idle_timer.sv
// Idle-cycle timer for the ACTIVE phase: counts cycles without a pop and reports
// each TIMEOUT_CYCLES-long stall as one tick in a saturating 8-bit count.
module output_limit_idle_timer #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       active,
    input  logic       rd_en,
    input  logic       clear,
    output logic [7:0] tick_cnt
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CW-1:0] idle_q, idle_d;
    logic [7:0]    tick_q, tick_d;

    always_comb begin
        idle_d = idle_q;
        tick_d = tick_q;
        if (!active || rd_en) begin
            idle_d = '0;
        end else if (idle_q == CW'(TIMEOUT_CYCLES - 1)) begin
            idle_d = '0;
            if (tick_q != 8'hFF) tick_d = tick_q + 8'd1;
        end else begin
            idle_d = idle_q + CW'(1);
        end
        if (clear) tick_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_q <= '0;
            tick_q <= '0;
        end else begin
            idle_q <= idle_d;
            tick_q <= tick_d;
        end
    end

    assign tick_cnt = tick_q;

endmodule

// File: rtl/output_limit_ctrl.sv
// Output-limit sequencer: snapshots a FIFO word grant on registration and gates
// exactly that many pops to the high-speed port. Optional OUTPUT_LIMIT_TIMEOUT_EN.
module output_limit_ctrl
    import output_limit_ctrl_pkg::*;
#(
    parameter int WORD_CNT_W     = OLC_WORD_CNT_W,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                  IFCLK,
    input  logic                  RESET_N,
    input  logic                  output_mode_limit,
    input  logic                  reg_output_limit,
    input  logic [WORD_CNT_W-1:0] output_limit_min,
    input  logic [WORD_CNT_W-1:0] fifo_words,
    input  logic                  fifo_not_empty,
    input  logic                  hs_rd_req,
    output logic                  fifo_rd_en,
    output logic [WORD_CNT_W-1:0] output_limit,
    output logic                  output_limit_done,
    output logic                  output_err_overflow,
    output logic [7:0]            hs_io_timeout
);

    olc_state_e            state_q, state_d;
    logic [WORD_CNT_W-1:0] remaining_q, remaining_d;
    logic [WORD_CNT_W-1:0] output_limit_q, output_limit_d;
    logic                  done_q, done_d;
    logic                  ovf_q, ovf_d;
    logic [WORD_CNT_W-1:0] grant;
    logic                  reg_acc;
    logic                  is_active;
    logic                  cnt_ok;

    always_comb begin
        grant     = (fifo_words >= output_limit_min) ? fifo_words : '0;
        is_active = (state_q == OLC_ACTIVE);
        reg_acc   = reg_output_limit && !is_active;
        cnt_ok    = is_active && (remaining_q != '0);
        fifo_rd_en = hs_rd_req & fifo_not_empty & (output_mode_limit ? cnt_ok : 1'b1);

        state_d        = state_q;
        remaining_d    = remaining_q;
        output_limit_d = output_limit_q;
        done_d         = done_q;

        if (is_active) begin
            // Leaving limit mode abandons the grant but keeps output_limit visible.
            if (!output_mode_limit) begin
                remaining_d = '0;
                state_d     = OLC_DONE;
                done_d      = 1'b1;
            end else if (fifo_rd_en) begin
                remaining_d = remaining_q - WORD_CNT_W'(1);
                if (remaining_q == WORD_CNT_W'(1)) begin
                    state_d = OLC_DONE;
                    done_d  = 1'b1;
                end
            end
        end else if (reg_acc) begin
            output_limit_d = grant;
            if (output_mode_limit && (grant != '0)) begin
                remaining_d = grant;
                state_d     = OLC_ACTIVE;
                done_d      = 1'b0;
            end else begin
                remaining_d = '0;
                state_d     = OLC_DONE;
                done_d      = 1'b1;
            end
        end

        ovf_d = ovf_q;
        if (output_mode_limit && hs_rd_req && !cnt_ok) ovf_d = 1'b1;
        if (reg_acc) ovf_d = 1'b0;
    end

    always_ff @(posedge IFCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q        <= OLC_IDLE;
            remaining_q    <= '0;
            output_limit_q <= '0;
            done_q         <= 1'b1;
            ovf_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            remaining_q    <= remaining_d;
            output_limit_q <= output_limit_d;
            done_q         <= done_d;
            ovf_q          <= ovf_d;
        end
    end

    assign output_limit        = output_limit_q;
    assign output_limit_done   = done_q;
    assign output_err_overflow = ovf_q;

`ifdef OUTPUT_LIMIT_TIMEOUT_EN
    output_limit_idle_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_idle_timer (
        .clk     (IFCLK),
        .rst_n   (RESET_N),
        .active  (is_active),
        .rd_en   (fifo_rd_en),
        .clear   (reg_acc),
        .tick_cnt(hs_io_timeout)
    );
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign hs_io_timeout      = '0;
`endif

endmodule

// File: tb/tb_output_limit_ctrl.sv
// Self-checking bench for output_limit_ctrl: directed scenarios plus random
// traffic against a transaction-level grant/pop model.
module tb_output_limit_ctrl;

    localparam int W   = 16;
    localparam int TMO = 16;

    logic         IFCLK = 1'b0;
    logic         RESET_N;
    logic         output_mode_limit;
    logic         reg_output_limit;
    logic [W-1:0] output_limit_min;
    logic [W-1:0] fifo_words;
    logic         fifo_not_empty;
    logic         hs_rd_req;
    logic         fifo_rd_en;
    logic [W-1:0] output_limit;
    logic         output_limit_done;
    logic         output_err_overflow;
    logic [7:0]   hs_io_timeout;

    int checks   = 0;
    int failures = 0;
    int pops     = 0;

    // Reference model: granted words, words still owed, and the status flags.
    int m_lim, m_left, m_tmo, m_idle;
    bit m_busy, m_done, m_ovf;

    output_limit_ctrl #(
        .WORD_CNT_W    (W),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .IFCLK              (IFCLK),
        .RESET_N            (RESET_N),
        .output_mode_limit  (output_mode_limit),
        .reg_output_limit   (reg_output_limit),
        .output_limit_min   (output_limit_min),
        .fifo_words         (fifo_words),
        .fifo_not_empty     (fifo_not_empty),
        .hs_rd_req          (hs_rd_req),
        .fifo_rd_en         (fifo_rd_en),
        .output_limit       (output_limit),
        .output_limit_done  (output_limit_done),
        .output_err_overflow(output_err_overflow),
        .hs_io_timeout      (hs_io_timeout)
    );

    always #5 IFCLK = ~IFCLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_lim = 0; m_left = 0; m_tmo = 0; m_idle = 0;
        m_busy = 0; m_done = 1; m_ovf = 0;
    endtask

    task automatic model_edge(input bit rd);
        bit acc, busy0;
        int left0, g;
        acc   = reg_output_limit && !m_busy;
        busy0 = m_busy;
        left0 = m_left;
        if (m_busy) begin
            if (!output_mode_limit) begin
                m_left = 0; m_busy = 0; m_done = 1;
            end else if (rd) begin
                m_left--;
                if (m_left == 0) begin m_busy = 0; m_done = 1; end
            end
        end else if (acc) begin
            g = (int'(fifo_words) >= int'(output_limit_min)) ? int'(fifo_words) : 0;
            m_lim = g;
            if (output_mode_limit && g > 0) begin
                m_busy = 1; m_left = g; m_done = 0;
            end else begin
                m_left = 0; m_done = 1;
            end
        end
        if (acc) m_ovf = 0;
        else if (output_mode_limit && hs_rd_req && !(busy0 && left0 > 0)) m_ovf = 1;
`ifdef OUTPUT_LIMIT_TIMEOUT_EN
        if (busy0 && !rd) begin
            m_idle++;
            if (m_idle == TMO) begin
                m_idle = 0;
                if (m_tmo < 255) m_tmo++;
            end
        end else begin
            m_idle = 0;
        end
        if (acc) m_tmo = 0;
`endif
    endtask

    // One clock: check everything mid-cycle, then advance the model on the edge.
    task automatic step();
        bit exp_rd;
        @(negedge IFCLK);
        exp_rd = output_mode_limit ? (hs_rd_req && fifo_not_empty && m_busy && m_left > 0)
                                   : (hs_rd_req && fifo_not_empty);
        chk("rd_en", 32'(fifo_rd_en), 32'(exp_rd));
        chk("limit", 32'(output_limit), 32'(m_lim));
        chk("done", 32'(output_limit_done), 32'(m_done));
        chk("ovf", 32'(output_err_overflow), 32'(m_ovf));
        chk("tmo", 32'(hs_io_timeout), 32'(m_tmo));
        if (fifo_rd_en) pops++;
        @(posedge IFCLK);
        model_edge(exp_rd);
        #1;
    endtask

    task automatic do_reg(input int fw, input int mn);
        fifo_words       = W'(fw);
        output_limit_min = W'(mn);
        reg_output_limit = 1'b1;
        step();
        reg_output_limit = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET_N = 1'b0;
        output_mode_limit = 1'b1; reg_output_limit = 1'b0;
        output_limit_min = '0; fifo_words = '0;
        fifo_not_empty = 1'b1; hs_rd_req = 1'b0;
        model_reset();
        #12;
        chk("rst_limit", 32'(output_limit), 32'd0);
        chk("rst_done", 32'(output_limit_done), 32'd1);
        chk("rst_ovf", 32'(output_err_overflow), 32'd0);
        chk("rst_tmo", 32'(hs_io_timeout), 32'd0);
        RESET_N = 1'b1;
        @(posedge IFCLK); #1;

        // Basic grant of 10 words
        do_reg(10, 0);
        hs_rd_req = 1'b1; pops = 0;
        repeat (10) step();
        hs_rd_req = 1'b0;
        step();
        chk("basic_pops", 32'(pops), 32'd10);
        chk("basic_limit", 32'(output_limit), 32'd10);
        chk("basic_done", 32'(output_limit_done), 32'd1);
        chk("basic_ovf", 32'(output_err_overflow), 32'd0);

        // Below minimum: zero grant, a request then flags overflow
        do_reg(3, 8);
        chk("below_limit", 32'(output_limit), 32'd0);
        chk("below_done", 32'(output_limit_done), 32'd1);
        hs_rd_req = 1'b1;
        step();
        hs_rd_req = 1'b0;
        chk("below_ovf", 32'(output_err_overflow), 32'd1);

        // Equal to minimum grants the full count
        do_reg(7, 7);
        chk("eqmin_limit", 32'(output_limit), 32'd7);
        chk("eqmin_ovf_clr", 32'(output_err_overflow), 32'd0);
        hs_rd_req = 1'b1; pops = 0;
        repeat (7) step();
        hs_rd_req = 1'b0;
        chk("eqmin_pops", 32'(pops), 32'd7);

        // Re-register while ACTIVE is ignored
        do_reg(5, 0);
        hs_rd_req = 1'b1; pops = 0;
        repeat (2) step();
        fifo_words = W'(20); reg_output_limit = 1'b1;
        step();
        reg_output_limit = 1'b0;
        repeat (2) step();
        hs_rd_req = 1'b0;
        step();
        chk("rereg_pops", 32'(pops), 32'd5);
        chk("rereg_limit", 32'(output_limit), 32'd5);
        chk("rereg_done", 32'(output_limit_done), 32'd1);

        // Mode drop mid-transfer
        do_reg(6, 0);
        hs_rd_req = 1'b1;
        repeat (2) step();
        output_mode_limit = 1'b0; hs_rd_req = 1'b0;
        step();
        chk("mdrop_done", 32'(output_limit_done), 32'd1);
        chk("mdrop_limit", 32'(output_limit), 32'd6);
        hs_rd_req = 1'b1; pops = 0;
        repeat (3) step();
        fifo_not_empty = 1'b0;
        step();
        fifo_not_empty = 1'b1; hs_rd_req = 1'b0;
        chk("mdrop_pass_pops", 32'(pops), 32'd3);
        chk("mdrop_ovf", 32'(output_err_overflow), 32'd0);
        output_mode_limit = 1'b1;

        // Asynchronous reset in the middle of a large grant
        do_reg(100, 0);
        hs_rd_req = 1'b1; pops = 0;
        repeat (40) step();
        chk("arst_pops", 32'(pops), 32'd40);
        #2 RESET_N = 1'b0;
        #1;
        model_reset();
        chk("arst_rd_en", 32'(fifo_rd_en), 32'd0);
        chk("arst_limit", 32'(output_limit), 32'd0);
        chk("arst_done", 32'(output_limit_done), 32'd1);
        chk("arst_ovf", 32'(output_err_overflow), 32'd0);
        chk("arst_tmo", 32'(hs_io_timeout), 32'd0);
        hs_rd_req = 1'b0;
        @(negedge IFCLK) RESET_N = 1'b1;
        @(posedge IFCLK); #1;

`ifdef OUTPUT_LIMIT_TIMEOUT_EN
        // Idle stall while ACTIVE reports ticks without ending the grant
        do_reg(4, 0);
        repeat (40) step();
        chk("tmo_ticks", 32'(hs_io_timeout), 32'd2);
        chk("tmo_still_busy", 32'(output_limit_done), 32'd0);
        hs_rd_req = 1'b1; pops = 0;
        repeat (4) step();
        hs_rd_req = 1'b0;
        chk("tmo_pops", 32'(pops), 32'd4);
        chk("tmo_done", 32'(output_limit_done), 32'd1);
`endif

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            output_mode_limit = ($urandom_range(0, 15) != 0);
            reg_output_limit  = ($urandom_range(0, 7) == 0);
            fifo_words        = W'($urandom_range(0, 30));
            output_limit_min  = ($urandom_range(0, 3) == 0) ? fifo_words : W'($urandom_range(0, 30));
            hs_rd_req         = ($urandom_range(0, 9) < 7);
            fifo_not_empty    = ($urandom_range(0, 9) < 8);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
